// File: rtl/shift_array_sequencer.sv
// ---------------------------------------------------------------------------
// shift_array_sequencer
//
// Owns a 4-word register bank {R3,R2,R1,R0} and steps it through the
// word-array shifter function once per clock for a programmed number of
// steps. The host loads the bank and starts a sequence; the controller
// reports progress with busy and finishes with a one-cycle done pulse.
//
// Handshake: start is accepted only in IDLE (load has priority in the same
// cycle). After an accepted start, busy is high for exactly `count` cycles.
// done is then high for exactly one cycle. start/load outside IDLE are
// dropped, never queued.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the `abort` input.
// An abort in RUN skips the step that edge and goes straight to DONE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   load       in   write data_in into the bank (IDLE only)
//   data_in    in   4*WIDTH load value {R3,R2,R1,R0}
//   start      in   begin a sequence (IDLE only)
//   dir        in   shifter select, latched at start
//   count      in   CNT_W step count, latched at start
//   ir         in   WIDTH right fill word, latched at start
//   il         in   WIDTH left fill word, latched at start
//   abort      in   (SHIFT_SEQ_ABORT_EN only) end RUN early
//   q          out  4*WIDTH bank contents {R3,R2,R1,R0}
//   busy       out  high while in RUN
//   done       out  one-cycle pulse in DONE
//   state_dbg  out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------
module shift_array_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [4*WIDTH-1:0]   data_in,
    input  logic                 start,
    input  logic                 dir,
    input  logic [CNT_W-1:0]     count,
    input  logic [WIDTH-1:0]     ir,
    input  logic [WIDTH-1:0]     il,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic [4*WIDTH-1:0]   q,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   r0, r1, r2, r3;
    logic               dir_q;
    logic [CNT_W-1:0]   remaining;
    logic [WIDTH-1:0]   ir_q, il_q;

    logic [WIDTH-1:0]   n0, n1, n2, n3;
    logic               abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // One step of the word-array shifter. dir=0 moves words toward R3 with
    // the right fill entering at R0; dir=1 moves words toward R0 with the
    // left fill entering at R3. The words crossing the ends are shifted by
    // one bit (logical, truncated to WIDTH).
    always_comb begin
        n0 = '0;
        n1 = '0;
        n2 = '0;
        n3 = '0;
        if (!dir_q) begin
            n0 = ir_q >> 1;
            n1 = r0;
            n2 = r1;
            n3 = r2 << 1;
        end else begin
            n0 = r1 >> 1;
            n1 = r2;
            n2 = r3;
            n3 = il_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            r0        <= '0;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            dir_q     <= 1'b0;
            remaining <= '0;
            ir_q      <= '0;
            il_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (load) begin
                        {r3, r2, r1, r0} <= data_in;
                    end else if (start) begin
                        dir_q     <= dir;
                        remaining <= count;
                        ir_q      <= ir;
                        il_q      <= il;
                        if (count != '0) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end else begin
                            // Zero-length sequence: skip RUN entirely.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_req) begin
                        // Bank keeps its partial result; no step this edge.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        {r3, r2, r1, r0} <= {n3, n2, n1, n0};
                        remaining        <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign q         = {r3, r2, r1, r0};
    assign state_dbg = state;

endmodule

// File: tb/tb_shift_array_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for shift_array_sequencer (WIDTH=4, CNT_W=4).
// Directed sequences; each completed sequence pushes its expected final bank
// and busy length into queues that a negedge monitor pops on every done.
// ---------------------------------------------------------------------------
module tb_shift_array_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int BW    = 4 * WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             load = 1'b0;
    logic [BW-1:0]    data_in = '0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [WIDTH-1:0] ir = '0;
    logic [WIDTH-1:0] il = '0;
    logic             abort = 1'b0;
    logic [BW-1:0]    q;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    shift_array_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_in   (data_in),
        .start     (start),
        .dir       (dir),
        .count     (count),
        .ir        (ir),
        .il        (il),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .q         (q),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int            exp_busy_q[$];
    int            checks = 0;
    int            errors = 0;
    int            done_seen = 0;
    int            done_expected = 0;
    int            busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: measures busy length and checks the bank on every done.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else if (done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with q=0x%0h expected no done at %0t", q, $time);
            end else begin
                check("done_q", 32'(q), 32'(exp_q.pop_front()));
                check("busy_len", 32'(busy_cnt), 32'(exp_busy_q.pop_front()));
            end
            busy_cnt = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_load(input logic [BW-1:0] v);
        load    = 1'b1;
        data_in = v;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic drive_start(input logic d, input logic [CNT_W-1:0] c,
                               input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] l);
        start = 1'b1;
        dir   = d;
        count = c;
        ir    = r;
        il    = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_seq(input logic [BW-1:0] v, input int blen);
        exp_q.push_back(v);
        exp_busy_q.push_back(blen);
        done_expected++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy && !done) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout: got busy=%0b done=%0b expected idle within 64 cycles", busy, done);
    endtask

    // Absolute time bound in case the DUT stalls in a way no task notices.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_q", 32'(q), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_state", 32'(state_dbg), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // dir=0, one step: 953F -> A3F5.
        drive_load(16'h953F);
        @(negedge clk);
        check("load_953f", 32'(q), 32'h953F);
        expect_seq(16'hA3F5, 1);
        drive_start(1'b0, 4'd1, 4'hA, 4'h0);
        wait_idle();

        // dir=1, two steps: 953F -> E951 -> EE92.
        drive_load(16'h953F);
        expect_seq(16'hEE92, 2);
        drive_start(1'b1, 4'd2, 4'h0, 4'h7);
        @(posedge clk);
        @(negedge clk);
        check("dir1_step1_q", 32'(q), 32'hE951);
        check("dir1_step1_busy", 32'(busy), 32'h1);
        wait_idle();

        // count=0: straight to DONE, bank untouched, busy never high.
        drive_load(16'h1234);
        expect_seq(16'h1234, 0);
        drive_start(1'b0, 4'd0, 4'hF, 4'hF);
        @(negedge clk);
        check("cnt0_done", 32'(done), 32'h1);
        check("cnt0_busy", 32'(busy), 32'h0);
        wait_idle();

        // load and start together: load wins, no RUN.
        load    = 1'b1;
        data_in = 16'hABCD;
        start   = 1'b1;
        count   = 4'd3;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("load_start_q", 32'(q), 32'hABCD);
        check("load_start_busy", 32'(busy), 32'h0);
        check("load_start_state", 32'(state_dbg), 32'h0);

        // 3 steps dir=0 ir=0 from ABCD: 6CD0, 8D00, A000. A start/load in
        // RUN with different settings must be ignored.
        expect_seq(16'hA000, 3);
        drive_start(1'b0, 4'd3, 4'h0, 4'h0);
        start   = 1'b1;
        load    = 1'b1;
        data_in = 16'hFFFF;
        dir     = 1'b1;
        count   = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        load  = 1'b0;
        wait_idle();

        // Reset on the 2nd of 5 RUN cycles: sequence discarded, no done.
        drive_load(16'h953F);
        drive_start(1'b0, 4'd5, 4'hA, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrun_rst_q", 32'(q), 32'h0);
        check("midrun_rst_busy", 32'(busy), 32'h0);
        check("midrun_rst_done", 32'(done), 32'h0);
        check("midrun_rst_state", 32'(state_dbg), 32'h0);
        repeat (6) @(negedge clk);

        // Maximum count, dir=1 il=5: A951, AA92, AAA4, AAA5 then stable.
        drive_load(16'h953F);
        expect_seq(16'hAAA5, 15);
        drive_start(1'b1, 4'd15, 4'h0, 4'h5);
        wait_idle();

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort after 2 steps (A3F5, 6F55): no third step, done follows.
        drive_load(16'h953F);
        expect_seq(16'h6F55, 3);
        drive_start(1'b0, 4'd5, 4'hA, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_done", 32'(done), 32'h1);
        wait_idle();
`endif

        repeat (4) @(negedge clk);
        check("leftover_expected", 32'(exp_q.size()), 32'h0);
        check("done_pulse_total", 32'(done_seen), 32'(done_expected));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
